timer_arbiter: RTL and testbench
================================

Name: timer_arbiter

Overview:
- One shared down-counter timer, time-multiplexed between NREQ requesters.
- Each requester asks for a delay of len cycles. A round-robin arbiter grants the timer to one requester, the timer counts that delay, and a one-cycle done pulse goes back to the winner.
- Sits beside the team's counter blocks as their sequencer and sharer, so blocks do not each instantiate a private counter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CW, 8, counter/length width in bits.

Ports:
- clk  input  1  clock, all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; bit i belongs to requester i.
- len  input  NREQ*CW  flattened lengths; requester i uses bits [i*CW +: CW].
- grant  output  NREQ  one-hot owner of the timer; all zero when idle.
- busy  output  1  high whenever state is not IDLE.
- done  output  NREQ  one-cycle completion pulse to the owner.
- cnt  output  CW  current counter value, for debug and observation.

Behaviour:
- Reset is asynchronous and active-high. When reset is asserted, everything clears immediately:
  - state=IDLE, grant=0, done=0, busy=0, cnt=0
  - round-robin pointer ptr=0, so requester 0 has top priority
  - This applies mid-operation too: no done is issued for an interrupted request.
- State machine: IDLE -> COUNT -> DONE -> IDLE. A request dropped during COUNT goes COUNT -> IDLE.
- IDLE:
  - If any req bit is high at the edge, select the first set bit searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - Registered results: grant=onehot(winner), cnt=len[winner], state=COUNT.
  - A len of 0 loads as 1.
  - If no req bit is high, stay in IDLE.
- COUNT:
  - Each edge: if cnt==1, go to DONE with cnt=0 and done[winner]=1. Otherwise cnt=cnt-1.
  - If req[winner] is low at an edge (abort), go to IDLE with grant=0, cnt=0, no done, and ptr=winner+1.
  - The winner's len is sampled only at grant. Later changes to len are ignored.
- DONE:
  - Lasts exactly one cycle with done[winner]=1 and grant still held.
  - Next edge: go to IDLE, grant=0, done=0, ptr=(winner+1) mod NREQ.
  - No arbitration happens in DONE, so there is always at least one IDLE cycle between owners.
- Latency:
  - The grant edge is the edge where IDLE samples req.
  - done is high in the cycle after edge (grant edge + max(len,1)).
  - grant stays high for max(len,1)+1 cycles.
- Fairness: a requester that keeps req high after its done competes again. Others are searched first, so no requester waits more than NREQ-1 grants.
- Outputs:
  - grant, done, busy and cnt are all registered; no combinational path from req or len to any output.
  - busy = (state != IDLE).
  - done bits are never high for non-owners.
- Widths: cnt is CW bits and never wraps. The decrement stops at 1 and the DONE transition sets 0.
- Simultaneous events: if the abort condition and cnt==1 occur on the same edge, abort wins and no done is issued.

Test Plan:
- Reset, then req=0001, len0=3 -> grant=0001 after edge E0; cnt shows 3,2,1; done=0001 for one cycle after E3; grant=0 after E4; busy high for exactly 4 cycles.
- req=1111 held, all len=2 -> grant order 0001, 0010, 0100, 1000, 0001; each grant lasts 3 cycles with 1 idle cycle between grants; one done per grant.
- req0 high with len0=0 -> treated as 1: done=0001 in the cycle after E1; grant high for 2 cycles.
- req2 granted with len=10, req2 dropped when cnt=5 -> next edge state=IDLE, grant=0, no done; a following req=1111 is granted to requester 3 first.
- Assert reset asynchronously mid-COUNT with cnt=7 -> grant, done, busy and cnt go to 0 immediately without a clock edge; after release, req=0110 grants requester 1 first (ptr=0).
- Change len1 from 4 to 9 while requester 1 is counting -> done still arrives 4 edges after the grant edge.

Source files
------------

// File: rtl/timer_arbiter.sv
// timer_arbiter: one shared down-counter timer, lent round-robin to NREQ requesters.
// The winner's len is loaded at grant, counted down to 1, then a one-cycle done pulse
// is returned to the winner before the timer goes back to idle.
module timer_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [NREQ-1:0]    done,
  output logic [CW-1:0]      cnt
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDone
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic [CW-1:0]   win_len;
  logic [PW-1:0]   owner_nxt;

  // Round-robin search: first set req bit starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr_q) + 32'(k)) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Winner's length, and the pointer value that follows the current owner.
  always_comb begin
    win_len   = len[win*CW +: CW];
    owner_nxt = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
  end

  // Main FSM; every output is a flop updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      cnt     <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            state_q <= StCount;
            busy    <= 1'b1;
            owner_q <= win;
            grant   <= NREQ'(1) << win;
            // A zero length still costs one count cycle.
            cnt     <= (win_len == '0) ? CW'(1) : win_len;
          end
        end
        StCount: begin
          // Abort has priority over completion on the same edge.
          if (!req[owner_q]) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            grant   <= '0;
            cnt     <= '0;
            ptr_q   <= owner_nxt;
          end else if (cnt == CW'(1)) begin
            state_q <= StDone;
            cnt     <= '0;
            done    <= grant;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          grant   <= '0;
          done    <= '0;
          ptr_q   <= owner_nxt;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          grant   <= '0;
          done    <= '0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with hand-computed expectations.
module tb_timer_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = 8;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic [NREQ-1:0]    done;
  logic [CW-1:0]      cnt;

  int n_chk;
  int n_pass;

  timer_arbiter #(
    .NREQ(NREQ),
    .CW  (CW)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .len  (len),
    .grant(grant),
    .busy (busy),
    .done (done),
    .cnt  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    len[i*CW +: CW] = CW'(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_cnt"},   32'(cnt),   32'd0);
  endtask

  initial begin
    logic [3:0] order [5];
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    req    = '0;
    len    = '0;
    #12;
    check_idle("rst");
    reset = 1'b0;

    // Single requester, len 3.
    req = 4'b0001;
    set_len(0, 3);
    tick();
    check("t1_grant_e0", 32'(grant), 32'h1);
    check("t1_cnt_e0",   32'(cnt),   32'd3);
    check("t1_busy_e0",  32'(busy),  32'd1);
    tick();
    check("t1_cnt_e1", 32'(cnt), 32'd2);
    tick();
    check("t1_cnt_e2",  32'(cnt),  32'd1);
    check("t1_done_e2", 32'(done), 32'd0);
    tick();
    check("t1_done_e3",  32'(done),  32'h1);
    check("t1_grant_e3", 32'(grant), 32'h1);
    check("t1_cnt_e3",   32'(cnt),   32'd0);
    check("t1_busy_e3",  32'(busy),  32'd1);
    req = '0;
    tick();
    check_idle("t1_e4");

    // All four requesting, len 2 each: strict rotation from 0.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("t2_grant", 32'(grant), 32'(order[g]));
      check("t2_cnt2",  32'(cnt),   32'd2);
      tick();
      check("t2_cnt1",  32'(cnt),   32'd1);
      check("t2_nodone", 32'(done), 32'd0);
      tick();
      check("t2_done",  32'(done),  32'(order[g]));
      check("t2_hold",  32'(grant), 32'(order[g]));
      if (g == 4) req = '0;
      tick();
      check("t2_gap_grant", 32'(grant), 32'd0);
      check("t2_gap_busy",  32'(busy),  32'd0);
    end

    // Zero length behaves as one.
    do_reset();
    req = 4'b0001;
    set_len(0, 0);
    tick();
    check("t3_grant_e0", 32'(grant), 32'h1);
    check("t3_cnt_e0",   32'(cnt),   32'd1);
    tick();
    check("t3_done_e1",  32'(done),  32'h1);
    check("t3_grant_e1", 32'(grant), 32'h1);
    req = '0;
    tick();
    check_idle("t3_e2");

    // Abort of requester 2 at cnt 5; pointer moves to 3.
    do_reset();
    req = 4'b0100;
    set_len(2, 10);
    tick();
    check("t4_grant", 32'(grant), 32'h4);
    check("t4_cnt10", 32'(cnt),   32'd10);
    for (int i = 0; i < 5; i++) tick();
    check("t4_cnt5", 32'(cnt), 32'd5);
    req = 4'b0000;
    tick();
    check_idle("t4_abort");
    req = 4'b1111;
    tick();
    check("t4_next_grant", 32'(grant), 32'h8);
    req = '0;
    tick();
    check("t4_abort2_grant", 32'(grant), 32'd0);

    // Async reset mid-count with ptr parked at 2; afterwards ptr must be 0.
    do_reset();
    req = 4'b0010;
    set_len(1, 2);
    tick();
    tick();
    tick();
    check("t5_done1", 32'(done), 32'h2);
    req = 4'b0100;
    set_len(2, 9);
    tick();
    tick();
    check("t5_grant2", 32'(grant), 32'h4);
    tick();
    tick();
    check("t5_cnt7", 32'(cnt), 32'd7);
    reset = 1'b1;
    #1;
    check_idle("t5_async");
    #1;
    reset = 1'b0;
    req   = 4'b0110;
    set_len(1, 4);
    tick();
    check("t5_ptr0_grant", 32'(grant), 32'h2);
    check("t6_cnt4",       32'(cnt),   32'd4);

    // len1 changes mid-count; the latched value still governs.
    set_len(1, 9);
    tick();
    check("t6_cnt3", 32'(cnt), 32'd3);
    tick();
    tick();
    check("t6_cnt1",   32'(cnt),  32'd1);
    check("t6_nodone", 32'(done), 32'd0);
    tick();
    check("t6_done", 32'(done), 32'h2);
    req = '0;
    tick();
    check("t6_release", 32'(grant), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
